reg_serial_out: RTL and testbench

//   Read-side companion to the loadable register: snapshots a register value on request and

---
 rtl/reg_serial_out.sv | 84 ++++++++
 tb/tb_reg_serial_out.sv | 118 +++++++++++
 2 files changed

// File: rtl/reg_serial_out.sv
// reg_serial_out: snapshots a register value and shifts it out on sclk/sdata, ending with a latch pulse and a done strobe.
module reg_serial_out #(
  parameter int size      = 8,
  parameter int MSB_FIRST = 1,
  parameter int CLKDIV    = 2
) (
  input  logic            sysclk,
  input  logic            reset_n,
  input  logic            clken,
  input  logic            start,
  input  logic [size-1:0] data_in,
  output logic            busy,
  output logic            done,
  output logic            sclk,
  output logic            sdata,
  output logic            latch
);
  localparam int DW = CLKDIV > 1 ? $clog2(CLKDIV) : 1;
  localparam int BW = $clog2(size);
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LATCH, DONE} state_t;
  state_t          state, state_n;
  logic [size-1:0] shadow, shadow_n;
  logic [BW-1:0]   bitc, bitc_n;
  logic [DW-1:0]   div, div_n;
  logic            last, busy_n, done_n, sclk_n, sdata_n, latch_n;
  assign last = div == DW'(CLKDIV - 1);
  always_ff @(posedge sysclk or negedge reset_n)
    if (!reset_n) begin
      state  <= IDLE;
      shadow <= '0;
      bitc   <= '0;
      div    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sclk   <= 1'b0;
      sdata  <= 1'b0;
      latch  <= 1'b0;
    end else begin
      state  <= state_n;
      shadow <= shadow_n;
      bitc   <= bitc_n;
      div    <= div_n;
      busy   <= busy_n;
      done   <= done_n;
      sclk   <= sclk_n;
      sdata  <= sdata_n;
      latch  <= latch_n;
    end
  always_comb begin
    state_n  = state;
    shadow_n = shadow;
    bitc_n   = bitc;
    div_n    = div;
    if (clken) begin
      div_n = (state == IDLE || state == DONE || last) ? '0 : div + 1'b1;
      case (state)
        IDLE: if (start) begin
          shadow_n = data_in;
          bitc_n   = '0;
          state_n  = SETUP;
        end
        SETUP: if (last) state_n = HIGH;
        HIGH: if (last) begin
          if (bitc == BW'(size - 1)) state_n = LATCH;
          else begin
            bitc_n   = bitc + 1'b1;
            shadow_n = MSB_FIRST != 0 ? shadow << 1 : shadow >> 1;
            state_n  = SETUP;
          end
        end
        LATCH: if (last) state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end
  // outputs are decoded from the next state so they land in flops alongside it
  always_comb begin
    busy_n  = state_n inside {SETUP, HIGH, LATCH};
    done_n  = state_n == DONE;
    sclk_n  = state_n == HIGH;
    latch_n = state_n == LATCH;
    sdata_n = busy_n & (MSB_FIRST != 0 ? shadow_n[size-1] : shadow_n[0]);
  end
endmodule

// File: tb/tb_reg_serial_out.sv
// tb_reg_serial_out: two configurations driven by shared random stimulus, each checked against a tick-count model and a frame scoreboard.
module tb_reg_serial_out;
  logic       sysclk = 1'b0;
  logic       reset_n, clken, start;
  logic [7:0] data_in;
  logic [1:0] busy, done, sclk, sdata, latch;
  int n_chk = 0;
  int n_fail = 0;
  always #5 sysclk = ~sysclk;
  task automatic chk(input string n, input int g, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", n, g, a, e, $time);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int CD = g == 0 ? 2 : 1;
    localparam int MF = g == 0 ? 1 : 0;
    localparam int L  = 2 * 8 * CD + CD + 1;
    int         rem, p, bi, cnt;
    logic [7:0] d, sr, e;
    logic [4:0] exp_o;
    logic       ps, pl;
    logic [7:0] q[$];
    reg_serial_out #(.size(8), .MSB_FIRST(MF), .CLKDIV(CD)) dut (
      .sysclk(sysclk), .reset_n(reset_n), .clken(clken), .start(start), .data_in(data_in),
      .busy(busy[g]), .done(done[g]), .sclk(sclk[g]), .sdata(sdata[g]), .latch(latch[g])
    );
    // rem counts clken ticks left until the block is back in IDLE
    always @(posedge sysclk or negedge reset_n)
      if (!reset_n) begin
        rem <= 0;
        q.delete();
      end else if (clken) begin
        if (rem == 0 && start) begin
          rem <= L;
          d   <= data_in;
          q.push_back(data_in);
        end else if (rem > 0) rem <= rem - 1;
      end
    always @(negedge sysclk) begin
      p = L - rem;
      exp_o = {rem > 1, rem == 1, 3'b000};
      if (rem > 1 && p < 16 * CD) begin
        bi = p / (2 * CD);
        exp_o[2] = 1'((p / CD) % 2);
        exp_o[1] = MF != 0 ? d[7-bi] : d[bi];
      end else if (rem > 1) begin
        exp_o[1] = MF != 0 ? d[0] : d[7];
        exp_o[0] = 1'b1;
      end
      chk("outputs{busy,done,sclk,sdata,latch}", g, {busy[g], done[g], sclk[g], sdata[g], latch[g]}, exp_o);
      if (!reset_n) begin
        sr = '0;
        cnt = 0;
      end else begin
        if (sclk[g] && !ps) begin
          sr = MF != 0 ? {sr[6:0], sdata[g]} : {sdata[g], sr[7:1]};
          cnt++;
        end
        if (latch[g] && !pl) begin
          chk("frame_pending", g, q.size() != 0, 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("latched_frame", g, sr, e);
            chk("sclk_edges", g, cnt, 8);
          end
          cnt = 0;
        end
        if (rem == 0) chk("idle_queue_empty", g, q.size(), 0);
      end
      ps = sclk[g];
      pl = latch[g];
    end
  end
  task automatic cyc(input logic ce, input logic st, input logic [7:0] dv);
    @(negedge sysclk);
    clken = ce;
    start = st;
    data_in = dv;
  endtask
  initial begin
    reset_n = 1'b0;
    clken = 1'b0;
    start = 1'b0;
    data_in = 8'h00;
    repeat (3) @(negedge sysclk);
    reset_n = 1'b1;
    cyc(1'b1, 1'b1, 8'hA5);
    for (int i = 0; i < 36; i++) cyc(1'b1, $urandom_range(0, 3) == 0, 8'hFF);
    for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'h01);
    for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0, 8'($urandom));
    cyc(1'b1, 1'b1, 8'h3C);
    for (int i = 0; i < 330; i++) cyc(i % 3 == 2, 1'b0, 8'($urandom));
    for (int i = 0; i < 300; i++) cyc(i % 3 == 0, $urandom_range(0, 7) == 0, 8'($urandom));
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b1, 8'($urandom));
    for (int i = 0; i < 60; i++) cyc(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 400; i++) cyc($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, 8'($urandom));
    for (int i = 0; i < 120; i++) cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'hC3);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    @(posedge sysclk);
    #2;
    chk("pre_reset_sclk_high", 0, sclk[0], 1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", 0, {busy[0], done[0], sclk[0], sdata[0], latch[0]}, 0);
    chk("async_reset_outputs", 1, {busy[1], done[1], sclk[1], sdata[1], latch[1]}, 0);
    repeat (3) @(negedge sysclk);
    reset_n = 1'b1;
    for (int i = 0; i < 80; i++) cyc(1'b1, 1'b0, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
